// File: rtl/tt_sweeper.sv
// Exhaustive truth-table sweeper: walks every input vector of a small combinational
// block, samples its outputs after a settle delay and scores them against EXPECT.
module tt_sweeper #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 4,
  parameter int SETTLE = 1,
  parameter logic [N_OUT*(2**N_IN)-1:0] EXPECT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [N_OUT-1:0]  dut_out,
  output logic [N_IN-1:0]   dut_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN+3:0]   err_count,
  output logic              first_fail_valid,
  output logic [N_IN-1:0]   first_fail_vec,
  output logic [N_OUT-1:0]  first_fail_mask,
  output logic              cap_valid,
  output logic [N_IN-1:0]   cap_vec,
  output logic [N_OUT-1:0]  cap_out,
  output logic [N_OUT-1:0]  cap_mism
);

  localparam int NV = 2**N_IN;
  localparam int EW = N_IN + 4;
  localparam logic [3:0] SETTLE_W = SETTLE[3:0];

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [3:0]        settle_q, settle_d;
  logic [EW-1:0]     err_q, err_d;
  logic              ffv_q, ffv_d;
  logic [N_IN-1:0]   ffvec_q, ffvec_d;
  logic [N_OUT-1:0]  ffmask_q, ffmask_d;
  logic              pass_q, pass_d;

  logic [N_OUT-1:0]  exp_bits;
  logic [N_OUT-1:0]  mism;
  logic [3:0]        mism_cnt;
  logic [EW-1:0]     err_sum;

  // Each channel owns a contiguous 2^N_IN slice of EXPECT, indexed by the vector.
  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_chan
      logic [NV-1:0] chan_tbl;
      assign chan_tbl     = EXPECT[gi*NV +: NV];
      assign exp_bits[gi] = chan_tbl[vec_q];
    end
  endgenerate

  assign mism = dut_out ^ exp_bits;

  always_comb begin
    mism_cnt = '0;
    for (int i = 0; i < N_OUT; i++) begin
      mism_cnt = mism_cnt + {3'b000, mism[i]};
    end
  end

  assign err_sum = err_q + {{(EW-4){1'b0}}, mism_cnt};

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffvec_d  = ffvec_q;
    ffmask_d = ffmask_q;
    pass_d   = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          err_d    = '0;
          ffv_d    = 1'b0;
          ffvec_d  = '0;
          ffmask_d = '0;
          pass_d   = 1'b0;
          vec_d    = '0;
          settle_d = SETTLE_W;
          state_d  = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (settle_q <= 4'd1) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        // An aborted sample is dropped entirely; pass stays at its cleared value.
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          err_d = err_sum;
          if ((mism != '0) && !ffv_q) begin
            ffv_d    = 1'b1;
            ffvec_d  = vec_q;
            ffmask_d = mism;
          end
          if (&vec_q) begin
            pass_d  = (err_sum == '0);
            state_d = S_DONE;
          end else begin
            vec_d    = vec_q + 1'b1;
            settle_d = SETTLE_W;
            state_d  = S_DRIVE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      ffv_q    <= 1'b0;
      ffvec_q  <= '0;
      ffmask_q <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      ffv_q    <= ffv_d;
      ffvec_q  <= ffvec_d;
      ffmask_q <= ffmask_d;
      pass_q   <= pass_d;
    end
  end

  assign dut_in           = vec_q;
  assign busy             = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
  assign done             = (state_q == S_DONE);
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
  assign first_fail_mask  = ffmask_q;

  // Capture fields read as zero outside SAMPLE so the port is quiet between beats.
  assign cap_valid = (state_q == S_SAMPLE);
  assign cap_vec   = cap_valid ? vec_q   : '0;
  assign cap_out   = cap_valid ? dut_out : '0;
  assign cap_mism  = cap_valid ? mism    : '0;

endmodule
